// File: rtl/tensor_cfg_arbiter.sv
// Round-robin arbiter sharing one tensor_interface config port among NUM_REQ requesters.
// Optional WAIT watchdog is built when TENSOR_ARB_TIMEOUT_EN is defined.
module tensor_cfg_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int CFG_W          = 107,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ*CFG_W-1:0] req_tdata,
  input  logic [NUM_REQ-1:0]       req_tvalid,
  output logic [NUM_REQ-1:0]       req_tready,
  output logic [CFG_W-1:0]         cfg_out_tdata,
  output logic                     cfg_out_tvalid,
  input  logic                     cfg_out_tready,
  input  logic                     op_done,
  output logic                     done_valid,
  output logic [ID_W-1:0]          done_id,
  output logic                     done_err,
  output logic                     busy
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("tensor_cfg_arbiter: NUM_REQ must be in 2..8");
  end
  if (CFG_W < 2 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_widths
    $error("tensor_cfg_arbiter: CFG_W must be >= 2 and TIMEOUT_CYCLES in 2..65536");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   grant_q;
  logic [CFG_W-1:0]  cfg_tdata_q;
  logic              cfg_tvalid_q;
  logic              done_valid_q;
  logic [ID_W-1:0]   done_id_q;

  logic              found;
  logic [ID_W-1:0]   grant_d;
  int                idx;

  // Search starts just past the last winner so the previous grantee has lowest priority.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    found   = 1'b0;
    grant_d = '0;
    idx     = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(rr_ptr_q) + off) % NUM_REQ;
      if (!found && req_tvalid[idx]) begin
        found   = 1'b1;
        grant_d = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_tready = '0;
    if (state_q == IDLE && found && !reset) req_tready[grant_d] = 1'b1;
  end

`ifdef TENSOR_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt_q;
  logic        done_err_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);
      grant_q      <= '0;
      cfg_tdata_q  <= '0;
      cfg_tvalid_q <= 1'b0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
`ifdef TENSOR_ARB_TIMEOUT_EN
      wait_cnt_q   <= '0;
      done_err_q   <= 1'b0;
`endif
    end else begin
      done_valid_q <= 1'b0;
`ifdef TENSOR_ARB_TIMEOUT_EN
      done_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (found) begin
            cfg_tdata_q  <= req_tdata[int'(grant_d)*CFG_W +: CFG_W];
            grant_q      <= grant_d;
            rr_ptr_q     <= grant_d;
            cfg_tvalid_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (cfg_out_tready) begin
            cfg_tvalid_q <= 1'b0;
            // A no-op descriptor never produces op_done, so complete it immediately.
            if (cfg_tdata_q[CFG_W-1 -: 2] == 2'b00) begin
              state_q      <= RESP;
              done_valid_q <= 1'b1;
              done_id_q    <= grant_q;
            end else begin
              state_q      <= WAIT;
`ifdef TENSOR_ARB_TIMEOUT_EN
              wait_cnt_q   <= '0;
`endif
            end
          end
        end
        WAIT: begin
          if (op_done) begin
            state_q      <= RESP;
            done_valid_q <= 1'b1;
            done_id_q    <= grant_q;
`ifdef TENSOR_ARB_TIMEOUT_EN
          end else if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            state_q      <= RESP;
            done_valid_q <= 1'b1;
            done_id_q    <= grant_q;
            done_err_q   <= 1'b1;
          end else begin
            wait_cnt_q   <= wait_cnt_q + 16'd1;
`endif
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_out_tdata  = cfg_tdata_q;
  assign cfg_out_tvalid = cfg_tvalid_q;
  assign done_valid     = done_valid_q;
  assign done_id        = done_id_q;
  assign busy           = (state_q != IDLE);
`ifdef TENSOR_ARB_TIMEOUT_EN
  assign done_err       = done_err_q;
`else
  assign done_err       = 1'b0;
`endif

endmodule
